// File: rtl/letc_core_pkg.sv
// Shared LETC core widths and fetch-stage sizing.
package letc_core_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned ILEN          = 32;
    localparam int unsigned F2_RSPQ_DEPTH = 4;

    typedef logic [XLEN-1:0] pc_t;
    typedef logic [ILEN-1:0] instr_t;

endpackage : letc_core_pkg

// File: rtl/letc_core_fifo_sync.sv
// Register-array synchronous FIFO with push/pop/flush, occupancy count and head.
module letc_core_fifo_sync #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Pointer/count next state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Data storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule : letc_core_fifo_sync

// File: rtl/letc_core_stage_fetch2_rspq.sv
// Fetch stage 2: pairs accepted F1 PCs with in-order IMSS responses, drops
// responses that were in flight across a flush, and bypasses a fresh response
// straight to decode when nothing is queued.
module letc_core_stage_fetch2_rspq
    import letc_core_pkg::*;
#(
    parameter int unsigned DEPTH   = F2_RSPQ_DEPTH,
    parameter int unsigned PC_W    = XLEN,
    parameter int unsigned INSTR_W = ILEN,
    parameter int unsigned RSP_W   = ILEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               f1_to_f2_valid,
    input  logic [PC_W-1:0]    f1_pc,
    output logic               f2_ready,
    input  logic               f2_flush,
    input  logic               f2_stall,
    input  logic               imss_rsp_valid,
    input  logic [RSP_W-1:0]   imss_rsp_data,
    output logic               f2_to_d_valid,
    output logic [PC_W-1:0]    f2_to_d_pc,
    output logic [INSTR_W-1:0] f2_to_d_instr
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0]   pc_cnt, iq_cnt;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [PC_W-1:0]    pc_head;
    logic [INSTR_W-1:0] iq_head;
    logic [SUM_W-1:0]   occ_c;
    logic               full_c, rsp_keep_c, iq_empty_c, head_valid_c;
    logic               acc_c, iq_push_c, iq_pop_c;

    // Capacity counts both live PC entries and responses still owed to a flush.
    assign occ_c      = SUM_W'(pc_cnt) + SUM_W'(drop_cnt_q);
    assign full_c     = occ_c >= SUM_W'(DEPTH);
    assign f2_ready   = !f2_flush && !full_c;
    assign acc_c      = f1_to_f2_valid && f2_ready;

    // Head is valid from the instruction queue or from a live bypassed response.
    assign rsp_keep_c    = imss_rsp_valid && (drop_cnt_q == '0);
    assign iq_empty_c    = (iq_cnt == '0);
    assign head_valid_c  = (pc_cnt != '0) && (!iq_empty_c || rsp_keep_c);
    assign f2_to_d_valid = head_valid_c && !f2_flush && !f2_stall;
    assign f2_to_d_pc    = pc_head;
    assign f2_to_d_instr = iq_empty_c ? imss_rsp_data[INSTR_W-1:0] : iq_head;

    // A bypassed response that is consumed this cycle never enters the queue.
    assign iq_push_c = rsp_keep_c && !(iq_empty_c && f2_to_d_valid);
    assign iq_pop_c  = f2_to_d_valid && !iq_empty_c;

    letc_core_fifo_sync #(.DEPTH(DEPTH), .WIDTH(PC_W)) u_pc_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (acc_c),
        .push_data_i (f1_pc),
        .pop_i       (f2_to_d_valid),
        .flush_i     (f2_flush),
        .count_o     (pc_cnt),
        .head_o      (pc_head)
    );

    letc_core_fifo_sync #(.DEPTH(DEPTH), .WIDTH(INSTR_W)) u_instr_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (iq_push_c),
        .push_data_i (imss_rsp_data[INSTR_W-1:0]),
        .pop_i       (iq_pop_c),
        .flush_i     (f2_flush),
        .count_o     (iq_cnt),
        .head_o      (iq_head)
    );

    // On flush every outstanding request becomes a drop, less any response arriving now.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (f2_flush) begin
            drop_cnt_d = CNT_W'(SUM_W'(drop_cnt_q) + SUM_W'(pc_cnt) - SUM_W'(iq_cnt)
                                - SUM_W'(imss_rsp_valid));
        end else if (imss_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    // Pending-drop counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    // Simulation checks on interface protocol and internal invariants.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown({f2_ready, f2_to_d_valid}));
            assert (!(f2_flush && f2_stall));
            assert (!(imss_rsp_valid && (drop_cnt_q == '0) && (pc_cnt == iq_cnt)));
            assert (f2_ready || f2_flush || f2_stall || full_c);
            assert (iq_cnt <= pc_cnt);
            assert (pc_cnt <= CNT_W'(DEPTH));
            assert (drop_cnt_q <= CNT_W'(DEPTH));
        end
    end

endmodule : letc_core_stage_fetch2_rspq
